l1_trigger_packager: RTL and testbench

Downstream of the L1 beamforming trigger, on `aclk`. It merges per-beam trigger pulses seen within a short coincidence window into one event. Each event carries a beam mask and a free-running timestamp. Events are buffered in a small FIFO and presented on an AXI4-Stream-style valid/ready output to the trigger readout.

---
 rtl/l1_trigger_packager.sv | 184 ++++++++++++++++++
 tb/tb_l1_trigger_packager.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/l1_trigger_packager.sv
`default_nettype none
// ============================================================================
// Module   : l1_trigger_packager
// Brief    : Merges beam trigger pulses within a coincidence window into
//            timestamped events and queues them on a valid/ready stream.
//            Optional per-beam event counters: define L1_PKT_BEAM_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module l1_trigger_packager #(
    parameter int NBEAMS        = 2,
    parameter int WINDOW_CLOCKS = 4,
    parameter int TS_BITS       = 32,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                      aclk,
    input  logic                      reset_i,
    input  logic [NBEAMS-1:0]         trig_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    output logic [TS_BITS+NBEAMS-1:0] tdata_o,
    output logic                      tvalid_o,
    input  logic                      tready_i,
    output logic [15:0]               overflow_count_o,
    output logic                      busy_o
`ifdef L1_PKT_BEAM_COUNT_EN
    ,
    output logic [NBEAMS*32-1:0]      beam_count_o
`endif
);

    localparam int          c_DW       = TS_BITS + NBEAMS;
    localparam int          c_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]  c_CNT_INIT = 8'(WINDOW_CLOCKS - 1);
    localparam logic [c_AW:0] c_DEPTH  = (c_AW + 1)'(FIFO_DEPTH);
    localparam bit          c_SINGLE   = (WINDOW_CLOCKS == 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_PUSH   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [NBEAMS-1:0]  r_mask;
    logic [NBEAMS-1:0]  w_mask_nxt;
    logic [TS_BITS-1:0] r_ts;
    logic [TS_BITS-1:0] r_ts_lat;
    logic [TS_BITS-1:0] w_ts_lat_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic               w_push;

    logic [c_DW-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    logic [15:0]        r_overflow;

    // ------------------------------------------------------------------
    // Free-running timestamp and FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            r_ts     <= '0;
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_ts_lat <= '0;
            r_cnt    <= '0;
        end else begin
            r_ts     <= r_ts + 1'b1;
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_ts_lat <= w_ts_lat_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_ts_lat_nxt = r_ts_lat;
        w_cnt_nxt    = r_cnt;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable_i && (|trig_i)) begin
                    w_mask_nxt   = trig_i;
                    w_ts_lat_nxt = r_ts;
                    w_cnt_nxt    = c_CNT_INIT;
                    w_state_nxt  = c_SINGLE ? S_PUSH : S_GATHER;
                end
            end
            S_GATHER: begin
                // enable_i is deliberately ignored here: an open window always completes
                w_mask_nxt = r_mask | trig_i;
                if (r_cnt == 8'd1) begin
                    w_state_nxt = S_PUSH;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy_o = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Show-ahead event FIFO; a full FIFO still accepts when popped this cycle
    // ------------------------------------------------------------------
    assign tvalid_o = (r_count != '0);
    assign w_pop    = tvalid_o && tready_i;
    assign w_wr     = w_push && ((r_count < c_DEPTH) || w_pop);
    assign w_drop   = w_push && !w_wr;
    assign tdata_o  = tvalid_o ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_ts_lat, r_mask};
        end
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{c_AW{1'b0}}, w_wr} - {{c_AW{1'b0}}, w_pop};
        end
    end

    // ------------------------------------------------------------------
    // Dropped-event counter, saturating; a clear coinciding with a drop counts it
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            r_overflow <= '0;
        end else if (clear_i) begin
            r_overflow <= {15'd0, w_drop};
        end else if (w_drop && (r_overflow != 16'hFFFF)) begin
            r_overflow <= r_overflow + 16'd1;
        end
    end

    assign overflow_count_o = r_overflow;

`ifdef L1_PKT_BEAM_COUNT_EN
    generate
        for (genvar b = 0; b < NBEAMS; b++) begin : g_beam_count
            logic [31:0] r_beam_cnt;
            logic        w_inc;

            assign w_inc = w_wr && r_mask[b];

            always_ff @(posedge aclk or posedge reset_i) begin
                if (reset_i) begin
                    r_beam_cnt <= '0;
                end else if (clear_i) begin
                    r_beam_cnt <= {31'd0, w_inc};
                end else if (w_inc) begin
                    r_beam_cnt <= r_beam_cnt + 32'd1;
                end
            end

            assign beam_count_o[b*32 +: 32] = r_beam_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1_trigger_packager.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_trigger_packager
// Brief    : Directed vector table plus multi-cycle sequences for the
//            trigger packager (default configuration).
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_trigger_packager;

    localparam int NB = 2;
    localparam int TS = 32;

    logic            aclk;
    logic            reset_i;
    logic [NB-1:0]   trig_i;
    logic            enable_i;
    logic            clear_i;
    logic [TS+NB-1:0] tdata_o;
    logic            tvalid_o;
    logic            tready_i;
    logic [15:0]     overflow_count_o;
    logic            busy_o;

    l1_trigger_packager #(
        .NBEAMS       (NB),
        .WINDOW_CLOCKS(4),
        .TS_BITS      (TS),
        .FIFO_DEPTH   (16)
    ) dut (
        .aclk            (aclk),
        .reset_i         (reset_i),
        .trig_i          (trig_i),
        .enable_i        (enable_i),
        .clear_i         (clear_i),
        .tdata_o         (tdata_o),
        .tvalid_o        (tvalid_o),
        .tready_i        (tready_i),
        .overflow_count_o(overflow_count_o),
        .busy_o          (busy_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference timestamp: value the next active edge will sample
    logic [TS-1:0] r_tb_ts;
    always @(posedge aclk or posedge reset_i) begin
        if (reset_i) r_tb_ts <= '0;
        else         r_tb_ts <= r_tb_ts + 1'b1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    typedef struct {
        logic [NB-1:0] t0, t1, t2, t3, t4;
        logic          en0, en1;
        logic          exp_valid;
        logic [NB-1:0] exp_mask;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [TS-1:0] exp_ts;
        logic [TS-1:0] f_ts;

        //            t0     t1     t2     t3     t4     en0   en1   valid mask
        vecs[0] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b01};
        vecs[1] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 2'b11};
        vecs[2] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 2'b01};
        vecs[3] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b11};
        vecs[4] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b11};
        vecs[5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b11};

        reset_i  = 1'b1;
        trig_i   = '0;
        enable_i = 1'b1;
        clear_i  = 1'b0;
        tready_i = 1'b1;
        repeat (3) tick();
        chk("reset_tvalid", 64'(tvalid_o), 64'd0);
        chk("reset_tdata", 64'(tdata_o), 64'd0);
        chk("reset_overflow", 64'(overflow_count_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        reset_i = 1'b0;

        for (int n = 0; n < 200 && r_tb_ts < 100; n++) tick();

        // ---------------- table-driven single windows ----------------
        for (int i = 0; i < 7; i++) begin
            trig_i = vecs[i].t0; enable_i = vecs[i].en0; exp_ts = r_tb_ts;
            tick();
            chk($sformatf("v%0d_busy", i), 64'(busy_o), 64'(vecs[i].exp_valid));
            trig_i = vecs[i].t1; enable_i = vecs[i].en1;
            tick();
            trig_i = vecs[i].t2; tick();
            trig_i = vecs[i].t3; tick();
            chk($sformatf("v%0d_early_valid", i), 64'(tvalid_o), 64'd0);
            trig_i = vecs[i].t4; tick();
            trig_i = '0; enable_i = 1'b1;
            chk($sformatf("v%0d_valid", i), 64'(tvalid_o), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("v%0d_data", i), 64'(tdata_o), 64'({exp_ts, vecs[i].exp_mask}));
            tick();
            chk($sformatf("v%0d_valid_drop", i), 64'(tvalid_o), 64'd0);
        end

        // ---------------- fill with stalled output, overflow 3 ----------------
        tready_i = 1'b0; trig_i = 2'b01; f_ts = r_tb_ts;
        repeat (95) tick();
        trig_i = '0;
        chk("fill_overflow", 64'(overflow_count_o), 64'd3);
        chk("fill_valid", 64'(tvalid_o), 64'd1);
        tick();
        chk("fill_hold_head", 64'(tdata_o), 64'({f_ts, 2'b01}));
        tready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d", k), 64'(tdata_o), 64'({f_ts + TS'(5 * k), 2'b01}));
            tick();
        end
        chk("drain_empty", 64'(tvalid_o), 64'd0);

        // ---------------- full FIFO with pop during PUSH ----------------
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        chk("clear_overflow", 64'(overflow_count_o), 64'd0);
        tready_i = 1'b0; trig_i = 2'b01; f_ts = r_tb_ts;
        repeat (84) tick();
        tready_i = 1'b1; trig_i = '0;
        tick();
        tready_i = 1'b0;
        chk("full_pop_overflow", 64'(overflow_count_o), 64'd0);
        chk("full_pop_head", 64'(tdata_o), 64'({f_ts + TS'(5), 2'b01}));

        // ---------------- drops, last one with coincident clear ----------------
        for (int w = 0; w < 3; w++) begin
            trig_i = 2'b01; tick();
            trig_i = '0; repeat (3) tick();
            clear_i = (w == 2);
            tick();
            clear_i = 1'b0;
            chk($sformatf("drop%0d_overflow", w), 64'(overflow_count_o), (w == 2) ? 64'd1 : 64'(w + 1));
        end
        tready_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("drain2_%0d", k), 64'(tdata_o), 64'({f_ts + TS'(5 * k), 2'b01}));
            tick();
        end
        chk("drain2_empty", 64'(tvalid_o), 64'd0);

        // ---------------- reset mid-GATHER with 2 words queued ----------------
        tready_i = 1'b0; trig_i = 2'b01;
        repeat (11) tick();
        trig_i = '0;
        repeat (2) tick();
        chk("pre_reset_valid", 64'(tvalid_o), 64'd1);
        chk("pre_reset_busy", 64'(busy_o), 64'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("async_reset_valid", 64'(tvalid_o), 64'd0);
        chk("async_reset_busy", 64'(busy_o), 64'd0);
        chk("async_reset_data", 64'(tdata_o), 64'd0);
        @(posedge aclk); #1;
        reset_i = 1'b0; tready_i = 1'b1; trig_i = 2'b01; enable_i = 1'b1;
        tick();
        trig_i = '0;
        repeat (3) tick();
        chk("post_reset_no_partial", 64'(tvalid_o), 64'd0);
        tick();
        chk("post_reset_valid", 64'(tvalid_o), 64'd1);
        chk("post_reset_ts0", 64'(tdata_o), 64'({32'd0, 2'b01}));
        tick();
        chk("post_reset_pop", 64'(tvalid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
